xilly_stream_fifo: RTL and testbench
====================================

XILLY_STREAM_FIFO -- requirements
Module: xilly_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream word width in bits (8, 16 or 32).
REQ-002 SHALL have parameter DEPTH_LOG2, default 9, giving a FIFO depth of 2**DEPTH_LOG2 words (4..12).
REQ-003 SHALL have parameter EOF_EN, default 1; 1 enables EOF generation, 0 ties user_r_eof to 0.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; all logic is clocked on the rising edge of bus_clk.
REQ-005 Port: bus_clk  input  1  sole clock.
REQ-006 Port: bus_rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: user_w_data  input  DATA_W  write-stream word.
REQ-008 Port: user_w_wren  input  1  write strobe.
REQ-009 Port: user_w_full  output  1  FIFO full.
REQ-010 Port: user_w_open  input  1  host write file open.
REQ-011 Port: user_r_data  output  DATA_W  read-stream word, registered.
REQ-012 Port: user_r_rden  input  1  read strobe.
REQ-013 Port: user_r_empty  output  1  FIFO empty.
REQ-014 Port: user_r_eof  output  1  end-of-file to host reader.
REQ-015 Port: user_r_open  input  1  host read file open.
REQ-016 Port: fill_level  output  DEPTH_LOG2+1  current word count.

Function
REQ-017 Storage SHALL be a circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo depth, plus a (DEPTH_LOG2+1)-bit occupancy counter.
REQ-018 user_w_full SHALL be (count == 2**DEPTH_LOG2); user_r_empty SHALL be (count == 0); both combinational from registered count.
REQ-019 A write with user_w_wren=1 and full=0 SHALL store the word and advance the write pointer; a write while full SHALL be ignored, even if a read occurs in the same cycle.
REQ-020 A read with user_r_rden=1 and empty=0 SHALL present the word at user_r_data on the next cycle (1-cycle latency, standard non-FWFT) and advance the read pointer; a read while empty SHALL be ignored and leave user_r_data unchanged.
REQ-021 An accepted read and an accepted write in the same cycle SHALL leave count unchanged; a write into an empty FIFO SHALL be readable no earlier than the following cycle.
REQ-022 A flush SHALL occur when user_w_open=0 and user_r_open=0 in the same cycle: pointers, count and EOF state cleared on the next edge; stored data need not be cleared.
REQ-023 EOF state machine (EOF_EN=1), states IDLE, STREAMING, DRAINING, EOF: IDLE->STREAMING when user_w_open rises while user_r_open=1; STREAMING->DRAINING when user_w_open falls; DRAINING->EOF when count==0 and no accepted write that cycle; any state->IDLE when user_r_open=0.
REQ-024 user_r_eof SHALL be 1 only in state EOF; user_r_empty is necessarily 1 whenever user_r_eof is 1.
REQ-025 user_w_open rising again in DRAINING or EOF SHALL return to STREAMING and deassert user_r_eof.
REQ-026 fill_level SHALL equal count, registered, updated the same edge as the pointers.

Reset
REQ-027 On bus_rst_n=0, asynchronously: pointers=0, count=0, user_r_data=0, EOF state=IDLE; thus user_w_full=0, user_r_empty=1, user_r_eof=0, fill_level=0.
REQ-028 Reset asserted mid-transfer SHALL discard all contents; deassertion SHALL be synchronised by the instantiating level; the block adds no reset synchroniser.

Structure
REQ-029 Package xilly_stream_pkg SHALL hold the EOF state enum and the depth-range limit constants.
REQ-030 Storage SHALL be a sub-module xilly_stream_ram: simple dual-port RAM, one write port, one registered read port, inferable as block RAM; pointers, count and FSM stay in the top.

Verification
REQ-031 DATA_W=32, DEPTH_LOG2=4, both opens=1: write 16 words 0..15 -> full=1 after the 16th, 17th write ignored; 16 reads return 0..15, each one cycle after rden; empty=1 after the last.
REQ-032 Simultaneous rden+wren at count=5 -> count stays 5; at count=0 -> write accepted, read ignored, count=1.
REQ-033 Write 3 words, drop user_w_open, read 3 -> user_r_eof=1 the cycle after count hits 0; drop user_r_open -> eof=0 next cycle.
REQ-034 Fill to 7, deassert both opens for 1 cycle -> count=0, empty=1, eof=0 next cycle.
REQ-035 Assert bus_rst_n=0 mid-burst between clock edges -> outputs reach reset values immediately, before the next edge.
REQ-036 DEPTH_LOG2=4, 40 interleaved writes and reads -> pointer wrap with data order preserved, 0..39 read back in order.

Source files
------------

// File: rtl/xilly_stream_pkg.sv
// Shared definitions for the Xillybus-style stream FIFO.
//   eof_state_e      : reader-side end-of-file tracking states
//   DepthLog2Min/Max : supported range of the DEPTH_LOG2 parameter
//   data_w_valid()   : legal stream word widths
package xilly_stream_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StStreaming = 2'd1,
    StDraining  = 2'd2,
    StEof       = 2'd3
  } eof_state_e;

  localparam int unsigned DepthLog2Min = 4;
  localparam int unsigned DepthLog2Max = 12;

  function automatic bit data_w_valid(input int unsigned w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/xilly_stream_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// The storage array has no reset so it maps onto block RAM; only the read
// output register is reset.
//   clk_i                : clock
//   rst_ni               : asynchronous active-low reset (read register only)
//   wr_en_i/addr/data    : write port
//   rd_en_i/rd_addr_i    : read request; rd_data_o valid on the next cycle
//   rd_data_o            : registered read data, holds when rd_en_i is low
module xilly_stream_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/xilly_stream_fifo.sv
// Stream FIFO between a Xillybus write file and a read file, with EOF signalling
// to the host reader once the writer has closed and the FIFO has drained.
//   bus_clk / bus_rst_n        : clock, asynchronous active-low reset
//   user_w_data/wren/full/open : write-stream side
//   user_r_data/rden/empty     : read-stream side (1-cycle read latency)
//   user_r_eof/open            : EOF to the reader, reader file open
//   fill_level                 : registered word count
module xilly_stream_fifo
  import xilly_stream_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter bit          EOF_EN     = 1'b1
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst_n,
  input  logic [DATA_W-1:0]     user_w_data,
  input  logic                  user_w_wren,
  output logic                  user_w_full,
  input  logic                  user_w_open,
  output logic [DATA_W-1:0]     user_r_data,
  input  logic                  user_r_rden,
  output logic                  user_r_empty,
  output logic                  user_r_eof,
  input  logic                  user_r_open,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int unsigned CntW = DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(1 << DEPTH_LOG2);

  if ((DEPTH_LOG2 < DepthLog2Min) || (DEPTH_LOG2 > DepthLog2Max) ||
      !data_w_valid(DATA_W)) begin : gen_param_err
    $error("xilly_stream_fifo: unsupported DATA_W or DEPTH_LOG2");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  w_open_q;
  eof_state_e            state_q;
  logic                  eof_q;

  logic full, empty, flush, wr_acc, rd_acc, w_open_rise;

  assign full        = (count_q == DepthCnt);
  assign empty       = (count_q == '0);
  // Both files closed: nobody can see the contents any more, so discard them.
  assign flush       = ~user_w_open & ~user_r_open;
  assign wr_acc      = user_w_wren & ~full & ~flush;
  assign rd_acc      = user_r_rden & ~empty & ~flush;
  assign w_open_rise = user_w_open & ~w_open_q;

  xilly_stream_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk_i     (bus_clk),
    .rst_ni    (bus_rst_n),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (user_w_data),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (user_r_data)
  );

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // EOF tracker; eof_q is registered alongside the state it decodes.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q  <= StIdle;
      eof_q    <= 1'b0;
      w_open_q <= 1'b0;
    end else begin
      w_open_q <= user_w_open;
      if (!user_r_open) begin
        state_q <= StIdle;
        eof_q   <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (w_open_rise) state_q <= StStreaming;
          end
          StStreaming: begin
            if (!user_w_open) state_q <= StDraining;
          end
          StDraining: begin
            if (w_open_rise) begin
              state_q <= StStreaming;
            end else if (empty && !wr_acc) begin
              state_q <= StEof;
              eof_q   <= 1'b1;
            end
          end
          StEof: begin
            if (w_open_rise) begin
              state_q <= StStreaming;
              eof_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            eof_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign user_w_full  = full;
  assign user_r_empty = empty;
  assign user_r_eof   = EOF_EN & eof_q;
  assign fill_level   = count_q;

endmodule

// File: tb/tb_xilly_stream_fifo.sv
module tb_xilly_stream_fifo;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n = 1'b0;
  logic [31:0] user_w_data = '0;
  logic        user_w_wren = 1'b0;
  logic        user_w_full;
  logic        user_w_open = 1'b0;
  logic [31:0] user_r_data;
  logic        user_r_rden = 1'b0;
  logic        user_r_empty;
  logic        user_r_eof;
  logic        user_r_open = 1'b0;
  logic [4:0]  fill_level;

  int n_cmp = 0;
  int n_fail = 0;

  xilly_stream_fifo #(
    .DATA_W     (32),
    .DEPTH_LOG2 (4),
    .EOF_EN     (1'b1)
  ) dut (
    .bus_clk      (bus_clk),
    .bus_rst_n    (bus_rst_n),
    .user_w_data  (user_w_data),
    .user_w_wren  (user_w_wren),
    .user_w_full  (user_w_full),
    .user_w_open  (user_w_open),
    .user_r_data  (user_r_data),
    .user_r_rden  (user_r_rden),
    .user_r_empty (user_r_empty),
    .user_r_eof   (user_r_eof),
    .user_r_open  (user_r_open),
    .fill_level   (fill_level)
  );

  always #5 bus_clk = ~bus_clk;

  // Reference model: a word queue, the reader's last word, and the EOF
  // state as 0=idle 1=streaming 2=draining 3=eof.
  localparam int Depth = 16;
  logic [31:0] mq[$];
  logic [31:0] m_rdata = '0;
  int          m_st = 0;
  logic        m_wo_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata   = '0;
    m_st      = 0;
    m_wo_prev = 1'b0;
  endtask

  // Applies one clock edge worth of the spec rules to the inputs seen at it.
  task automatic model_update();
    bit flush, mfull, mempty, wacc, racc, rise;
    flush  = !user_w_open && !user_r_open;
    mfull  = (mq.size() == Depth);
    mempty = (mq.size() == 0);
    wacc   = user_w_wren && !mfull && !flush;
    racc   = user_r_rden && !mempty && !flush;
    rise   = user_w_open && !m_wo_prev;
    if (!user_r_open) m_st = 0;
    else begin
      case (m_st)
        0: if (rise) m_st = 1;
        1: if (!user_w_open) m_st = 2;
        2: if (rise) m_st = 1; else if (mempty && !wacc) m_st = 3;
        default: if (rise) m_st = 1;
      endcase
    end
    if (racc) m_rdata = mq.pop_front();
    if (wacc) mq.push_back(user_w_data);
    if (flush) mq.delete();
    m_wo_prev = user_w_open;
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
    if (!bus_rst_n) model_reset();
    else model_update();
  endtask

  task automatic write_word(input logic [31:0] d);
    user_w_data = d;
    user_w_wren = 1'b1;
    tick();
    user_w_wren = 1'b0;
  endtask

  task automatic read_word();
    user_r_rden = 1'b1;
    tick();
    user_r_rden = 1'b0;
  endtask

  // Every falling edge: DUT against model.
  always @(negedge bus_clk) begin
    check("full", {31'd0, user_w_full}, {31'd0, mq.size() == Depth});
    check("empty", {31'd0, user_r_empty}, {31'd0, mq.size() == 0});
    check("fill", {27'd0, fill_level}, mq.size());
    check("rdata", user_r_data, m_rdata);
    check("eof", {31'd0, user_r_eof}, {31'd0, m_st == 3});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick();
    tick();
    check("rst_full", {31'd0, user_w_full}, 32'd0);
    check("rst_empty", {31'd0, user_r_empty}, 32'd1);
    check("rst_eof", {31'd0, user_r_eof}, 32'd0);
    check("rst_fill", {27'd0, fill_level}, 32'd0);
    check("rst_rdata", user_r_data, 32'd0);
    bus_rst_n = 1'b1;
    tick();
    user_w_open = 1'b1;
    user_r_open = 1'b1;
    tick();

    // Fill to the top, one overflow, then drain in order.
    for (int i = 0; i < 16; i++) write_word(i);
    check("fill16_full", {31'd0, user_w_full}, 32'd1);
    check("fill16_lvl", {27'd0, fill_level}, 32'd16);
    write_word(32'd99);
    check("ovf_lvl", {27'd0, fill_level}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      read_word();
      check("drain_data", user_r_data, i);
    end
    check("drain_empty", {31'd0, user_r_empty}, 32'd1);

    // Simultaneous read and write at count 5 and at count 0.
    for (int i = 0; i < 5; i++) write_word(100 + i);
    user_r_rden = 1'b1;
    write_word(32'd105);
    user_r_rden = 1'b0;
    check("rw5_lvl", {27'd0, fill_level}, 32'd5);
    check("rw5_data", user_r_data, 32'd100);
    for (int i = 0; i < 5; i++) read_word();
    check("rw_drain_data", user_r_data, 32'd105);
    user_r_rden = 1'b1;
    write_word(32'd106);
    user_r_rden = 1'b0;
    check("rw0_lvl", {27'd0, fill_level}, 32'd1);
    check("rw0_data", user_r_data, 32'd105);
    read_word();
    check("rw0_read", user_r_data, 32'd106);

    // EOF after the writer closes and the FIFO drains.
    for (int i = 0; i < 3; i++) write_word(200 + i);
    user_w_open = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) read_word();
    check("eof_lvl0", {27'd0, fill_level}, 32'd0);
    check("eof_early", {31'd0, user_r_eof}, 32'd0);
    tick();
    check("eof_set", {31'd0, user_r_eof}, 32'd1);
    check("eof_empty", {31'd0, user_r_empty}, 32'd1);
    user_r_open = 1'b0;
    tick();
    check("eof_clr", {31'd0, user_r_eof}, 32'd0);
    user_w_open = 1'b1;
    user_r_open = 1'b1;
    tick();

    // Flush with both files closed.
    for (int i = 0; i < 7; i++) write_word(300 + i);
    check("flush_pre", {27'd0, fill_level}, 32'd7);
    user_w_open = 1'b0;
    user_r_open = 1'b0;
    tick();
    check("flush_lvl", {27'd0, fill_level}, 32'd0);
    check("flush_empty", {31'd0, user_r_empty}, 32'd1);
    check("flush_eof", {31'd0, user_r_eof}, 32'd0);
    user_w_open = 1'b1;
    user_r_open = 1'b1;
    tick();

    // 40 interleaved words, wrapping the 16-entry pointers.
    for (int i = 0; i < 40; i++) begin
      user_w_data = i;
      user_w_wren = 1'b1;
      user_r_rden = (i >= 3);
      tick();
      if (i >= 3) check("wrap_data", user_r_data, i - 3);
    end
    user_w_wren = 1'b0;
    user_r_rden = 1'b0;
    for (int i = 37; i < 40; i++) begin
      read_word();
      check("wrap_tail", user_r_data, i);
    end

    // Asynchronous reset between edges during a burst.
    for (int i = 0; i < 5; i++) write_word(500 + i);
    #2;
    bus_rst_n = 1'b0;
    #1;
    check("arst_fill", {27'd0, fill_level}, 32'd0);
    check("arst_full", {31'd0, user_w_full}, 32'd0);
    check("arst_empty", {31'd0, user_r_empty}, 32'd1);
    check("arst_eof", {31'd0, user_r_eof}, 32'd0);
    check("arst_rdata", user_r_data, 32'd0);
    model_reset();
    tick();
    bus_rst_n = 1'b1;
    tick();

    // Randomized traffic with occasional open/close of either file.
    for (int c = 0; c < 3000; c++) begin
      user_w_wren = user_w_open && ($urandom_range(0, 99) < 55);
      user_r_rden = ($urandom_range(0, 99) < 50);
      user_w_data = $urandom;
      if ($urandom_range(0, 99) < 3) user_w_open = ~user_w_open;
      if ($urandom_range(0, 199) < 2) user_r_open = ~user_r_open;
      tick();
    end
    user_w_wren = 1'b0;
    user_r_rden = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
